nrisc_ctrl_unit: RTL and testbench

Multi-cycle control unit for the NRISC 16-bit core, the parametrised successor of the first-generation decode FSM. It decodes the 16-bit instruction word ({opcode[15:12], rd[11:8], rf1[7:4], rf2[3:0]}) and drives the ALU, register file, data memory, PC mux and external call stack. Compared with the first generation it adds:
- single-edge operation with synchronous reset;
- a memory ready handshake;
- a configurable call-stack depth with overflow/underflow detection;
- vectored interrupts;
- a two-cycle TWC;
- HALT/WAIT/SLEEP states.

---
 rtl/nrisc_pkg.sv | 137 +++++++++++++
 rtl/nrisc_sp_counter.sv | 31 +++
 rtl/nrisc_ctrl_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_nrisc_ctrl_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared encodings for the NRISC control unit: opcodes, ALU codes, state
// enum, mux selects and a small instruction classifier used by the FSM.
package nrisc_pkg;

  // Major opcodes (instr[15:12])
  localparam logic [3:0] OP_SYS = 4'h0;
  localparam logic [3:0] OP_LI  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_SW  = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JM  = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8;
  localparam logic [3:0] OP_XOR = 4'hC;
  localparam logic [3:0] OP_D   = 4'hD;
  localparam logic [3:0] OP_E   = 4'hE;
  localparam logic [3:0] OP_F   = 4'hF;

  // System sub-ops (instr[11:8])
  localparam logic [3:0] SYS_NOP   = 4'h0;
  localparam logic [3:0] SYS_HALT  = 4'h1;
  localparam logic [3:0] SYS_WAIT  = 4'h2;
  localparam logic [3:0] SYS_SLEEP = 4'h3;
  localparam logic [3:0] SYS_CALL  = 4'h4;
  localparam logic [3:0] SYS_RET   = 4'h5;
  localparam logic [3:0] SYS_RETI  = 4'h6;
  localparam logic [3:0] SYS_EI    = 4'h7;
  localparam logic [3:0] SYS_DI    = 4'h8;

  // F-group sub-ops (instr[3:0])
  localparam logic [3:0] FN_NOT = 4'h0;
  localparam logic [3:0] FN_TWC = 4'h1;
  localparam logic [3:0] FN_INC = 4'h2;
  localparam logic [3:0] FN_DEC = 4'h3;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_NOT = 4'h7;

  localparam logic [1:0] PC_NEXT  = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_STACK = 2'd2;
  localparam logic [1:0] PC_IRQ   = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  localparam logic [1:0] STK_NONE = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;

  localparam logic [15:0] IRQ_VECTOR = 16'h0010;

  typedef enum logic [2:0] {
    S_EXEC  = 3'd0,
    S_MEM   = 3'd1,
    S_TWC   = 3'd2,
    S_WAIT  = 3'd3,
    S_SLEEP = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  // Instruction classes; everything the FSM needs to know about an opcode
  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_LI, C_LW, C_SW, C_JMP, C_JCOND, C_TWC,
    C_HALT, C_WAIT, C_SLEEP, C_CALL, C_RET, C_RETI, C_EI, C_DI
  } cls_e;

  function automatic cls_e classify(logic [15:0] i);
    cls_e c;
    c = C_NOP;
    case (i[15:12])
      OP_SYS: begin
        case (i[11:8])
          SYS_HALT:  c = C_HALT;
          SYS_WAIT:  c = C_WAIT;
          SYS_SLEEP: c = C_SLEEP;
          SYS_CALL:  c = C_CALL;
          SYS_RET:   c = C_RET;
          SYS_RETI:  c = C_RETI;
          SYS_EI:    c = C_EI;
          SYS_DI:    c = C_DI;
          default:   c = C_NOP;
        endcase
      end
      OP_LI:                c = C_LI;
      OP_LW:                c = C_LW;
      OP_SW:                c = C_SW;
      OP_JMP:               c = C_JMP;
      OP_JZ, OP_JC, OP_JM:  c = C_JCOND;
      OP_F: begin
        case (i[3:0])
          FN_NOT, FN_INC, FN_DEC: c = C_ALU;
          FN_TWC:                 c = C_TWC;
          default:                c = C_NOP;
        endcase
      end
      default:              c = C_ALU;  // 8..E
    endcase
    return c;
  endfunction

  // ALU function for single-cycle ALU-class instructions
  function automatic logic [3:0] alu_code(logic [15:0] i);
    logic [3:0] code;
    case (i[15:12])
      OP_D: code = {i[0], 3'h5};
      OP_E: code = {i[0], 3'h6};
      OP_F: begin
        case (i[3:0])
          FN_INC:  code = ALU_ADD;
          FN_DEC:  code = ALU_SUB;
          default: code = ALU_NOT;
        endcase
      end
      default: code = i[15:12] - OP_ADD;
    endcase
    return code;
  endfunction

  // Conditional branch test: JZ flag[1], JC flag[2], JM flag[0]
  function automatic logic jump_taken(logic [15:0] i, logic [2:0] f);
    logic t;
    case (i[15:12])
      OP_JZ:   t = f[1];
      OP_JC:   t = f[2];
      OP_JM:   t = f[0];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nrisc_sp_counter.sv
// Call-stack depth counter; reports full/empty so the control unit can
// suppress pushes and pops that would run off either end.
module nrisc_sp_counter #(
  parameter int STACK_DEPTH = 8,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  output logic full,
  output logic empty
);

  logic [SP_W-1:0] sp;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  // Depth tracking; push and pop never arrive together
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/nrisc_ctrl_unit.sv
// Multi-cycle control unit for the NRISC 16-bit core. Registered state is
// limited to the FSM state, ie, stack depth and the sticky stack errors;
// every other output is decoded combinationally and held at 0 during rst.
//
// Memory handshake: the unit raises mem_req in S_MEM and holds it, with
// address and write data steady, until it sees mem_ready=1 on a rising
// edge; that cycle completes the access and mem_ready is ignored elsewhere.
module nrisc_ctrl_unit
  import nrisc_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic [2:0]  alu_flags,
  input  logic        irq,
  input  logic        wake,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        alu_incdec,
  output logic [3:0]  rd,
  output logic [3:0]  rf1,
  output logic [3:0]  rf2,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        mem_addr_le,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  pc_sel,
  output logic        pc_en,
  output logic [1:0]  stack_op,
  output logic        stack_ovf,
  output logic        stack_unf,
  output logic        ie,
  output logic [2:0]  state
);

  state_e state_q, state_d;
  logic   ie_q, ie_d, ovf_q, unf_q;
  logic   full, empty;
  cls_e   cls;
  logic   take_irq, exec_go, push_req, pop_req, ovf_hit, unf_hit;

  assign cls = classify(instr);

  // An interrupt replaces the instruction in S_EXEC and is also the exit
  // path from S_WAIT / S_SLEEP; it is never taken while instr is stalled.
  assign take_irq = ie_q && irq &&
                    ((state_q == S_EXEC && instr_valid) ||
                     state_q == S_WAIT || state_q == S_SLEEP);
  assign exec_go  = (state_q == S_EXEC) && instr_valid && !take_irq;
  assign push_req = take_irq || (exec_go && cls == C_CALL);
  assign pop_req  = exec_go && (cls == C_RET || cls == C_RETI);
  assign ovf_hit  = push_req && full;
  assign unf_hit  = pop_req && empty;

  nrisc_sp_counter #(
    .STACK_DEPTH(STACK_DEPTH),
    .SP_W       (SP_W)
  ) u_sp (
    .clk  (clk),
    .rst  (rst),
    .push (stack_op == STK_PUSH),
    .pop  (stack_op == STK_POP),
    .full (full),
    .empty(empty)
  );

  // State register plus ie and sticky stack error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EXEC;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_q | ovf_hit;
      unf_q   <= unf_q | unf_hit;
    end
  end

  // Next state and next interrupt-enable
  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    if (take_irq) ie_d = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (ovf_hit || unf_hit) begin
          state_d = S_HALT;
        end else if (exec_go) begin
          case (cls)
            C_LW, C_SW: state_d = S_MEM;
            C_TWC:      state_d = S_TWC;
            C_HALT:     state_d = S_HALT;
            C_WAIT:     state_d = S_WAIT;
            C_SLEEP:    state_d = S_SLEEP;
            C_RETI:     ie_d = 1'b1;
            C_EI:       ie_d = 1'b1;
            C_DI:       ie_d = 1'b0;
            default:    ;
          endcase
        end
      end
      S_MEM:   if (mem_ready) state_d = S_EXEC;
      S_TWC:   state_d = S_EXEC;
      S_WAIT:  begin
        if (ovf_hit) state_d = S_HALT;
        else if (take_irq || wake) state_d = S_EXEC;
      end
      S_SLEEP: begin
        if (ovf_hit) state_d = S_HALT;
        else if (irq) state_d = S_EXEC;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_EXEC;
    endcase
  end

  // Output decode from state, instr, flags and stack depth
  always_comb begin
    alu_op      = ALU_ADD;
    alu_incdec  = 1'b0;
    rd          = '0;
    rf1         = '0;
    rf2         = '0;
    reg_we      = 1'b0;
    wb_sel      = WB_ALU;
    mem_addr_le = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_sel      = PC_NEXT;
    pc_en       = 1'b0;
    stack_op    = STK_NONE;
    stack_ovf   = 1'b0;
    stack_unf   = 1'b0;
    ie          = 1'b0;
    state       = '0;
    if (!rst) begin
      rd        = instr[11:8];
      rf1       = instr[7:4];
      rf2       = instr[3:0];
      stack_ovf = ovf_q;
      stack_unf = unf_q;
      ie        = ie_q;
      state     = state_q;
      if (take_irq) begin
        pc_sel = PC_IRQ;
        if (!full) begin
          stack_op = STK_PUSH;
          pc_en    = 1'b1;
        end
      end else begin
        case (state_q)
          S_EXEC: begin
            if (instr_valid) begin
              case (cls)
                C_ALU: begin
                  alu_op     = alu_code(instr);
                  alu_incdec = (instr[15:12] == OP_F) &&
                               (instr[3:0] == FN_INC || instr[3:0] == FN_DEC);
                  reg_we     = 1'b1;
                  pc_en      = 1'b1;
                end
                C_LI: begin
                  reg_we = 1'b1;
                  wb_sel = WB_IMM;
                  pc_en  = 1'b1;
                end
                C_LW, C_SW: mem_addr_le = 1'b1;
                C_JMP: begin
                  pc_sel = PC_ALU;
                  pc_en  = 1'b1;
                end
                C_JCOND: begin
                  if (jump_taken(instr, alu_flags)) pc_sel = PC_ALU;
                  pc_en = 1'b1;
                end
                // First half of TWC: rd <= ~rf1, PC held
                C_TWC: begin
                  alu_op = ALU_NOT;
                  reg_we = 1'b1;
                end
                C_CALL: begin
                  pc_sel = PC_ALU;
                  if (!full) begin
                    stack_op = STK_PUSH;
                    pc_en    = 1'b1;
                  end
                end
                C_RET, C_RETI: begin
                  pc_sel = PC_STACK;
                  if (!empty) begin
                    stack_op = STK_POP;
                    pc_en    = 1'b1;
                  end
                end
                default: pc_en = 1'b1;
              endcase
            end
          end
          S_MEM: begin
            mem_req = 1'b1;
            // Stores route rd through the ALU (rd AND rd) as write data
            if (cls == C_SW) begin
              rf1    = instr[11:8];
              rf2    = instr[11:8];
              alu_op = ALU_AND;
              mem_we = 1'b1;
            end
            if (mem_ready) begin
              pc_en = 1'b1;
              if (cls == C_LW) begin
                reg_we = 1'b1;
                wb_sel = WB_MEM;
              end
            end
          end
          // Second half of TWC: rd <= rd + 1
          S_TWC: begin
            alu_incdec = 1'b1;
            rf1        = instr[11:8];
            reg_we     = 1'b1;
            pc_en      = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrisc_ctrl_unit.sv
// Directed bench for nrisc_ctrl_unit with STACK_DEPTH=2: a table of
// single-cycle instructions followed by multi-cycle sequences.
module tb_nrisc_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic [2:0]  alu_flags;
  logic        irq, wake, mem_ready;
  logic [3:0]  alu_op, rd, rf1, rf2;
  logic        alu_incdec, reg_we, mem_addr_le, mem_req, mem_we, pc_en;
  logic [1:0]  wb_sel, pc_sel, stack_op;
  logic        stack_ovf, stack_unf, ie;
  logic [2:0]  state;

  always #5 clk = ~clk;

  nrisc_ctrl_unit #(.STACK_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .alu_flags(alu_flags), .irq(irq), .wake(wake), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_incdec(alu_incdec), .rd(rd), .rf1(rf1), .rf2(rf2),
    .reg_we(reg_we), .wb_sel(wb_sel), .mem_addr_le(mem_addr_le),
    .mem_req(mem_req), .mem_we(mem_we), .pc_sel(pc_sel), .pc_en(pc_en),
    .stack_op(stack_op), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
    .ie(ie), .state(state)
  );

  typedef struct packed {
    logic [3:0] alu_op;
    logic       incdec;
    logic [3:0] rd;
    logic [3:0] rf1;
    logic [3:0] rf2;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       le;
    logic       req;
    logic       we;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic [1:0] stk;
    logic       ovf;
    logic       unf;
    logic       ie;
    logic [2:0] st;
  } out_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [2:0]  flags;
    logic [3:0]  alu_op;
    logic        incdec;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_sel;
    logic        ie;
  } vec_t;

  out_t act;
  assign act = {alu_op, alu_incdec, rd, rf1, rf2, reg_we, wb_sel, mem_addr_le,
                mem_req, mem_we, pc_sel, pc_en, stack_op, stack_ovf, stack_unf,
                ie, state};

  int   errors = 0;
  int   checks = 0;
  out_t e;
  vec_t tbl[22];

  function automatic out_t base(logic [15:0] i, logic iev, logic [2:0] st);
    out_t o;
    o     = '0;
    o.rd  = i[11:8];
    o.rf1 = i[7:4];
    o.rf2 = i[3:0];
    o.ie  = iev;
    o.st  = st;
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    @(negedge clk);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr = 16'h8312; instr_valid = 1'b1; alu_flags = 3'b111;
    irq = 1'b1; wake = 1'b1; mem_ready = 1'b1;
    tick();
    check("reset_zero", '0);
    tick();
    rst = 1'b0; instr_valid = 1'b0; alu_flags = '0;
    irq = 1'b0; wake = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"add",    16'h8312, 3'b000, 4'h0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[1]  = '{"sub",    16'h9abc, 3'b000, 4'h1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[2]  = '{"and",    16'hA123, 3'b000, 4'h2, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[3]  = '{"or",     16'hB000, 3'b000, 4'h3, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[4]  = '{"xor",    16'hC456, 3'b000, 4'h4, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[5]  = '{"op_d1",  16'hD121, 3'b000, 4'hD, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[6]  = '{"op_e0",  16'hE120, 3'b000, 4'h6, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[7]  = '{"not",    16'hF120, 3'b000, 4'h7, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[8]  = '{"inc",    16'hF342, 3'b000, 4'h0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[9]  = '{"dec",    16'hF343, 3'b000, 4'h1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0};
    tbl[10] = '{"li",     16'h17A5, 3'b000, 4'h0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0};
    tbl[11] = '{"jmp",    16'h4012, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
    tbl[12] = '{"jz_t",   16'h5012, 3'b010, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
    tbl[13] = '{"jz_n",   16'h5012, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[14] = '{"jc_t",   16'h6012, 3'b100, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
    tbl[15] = '{"jc_n",   16'h6012, 3'b010, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[16] = '{"jm_t",   16'h7012, 3'b001, 4'h0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0};
    tbl[17] = '{"nop",    16'h0000, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[18] = '{"ei",     16'h0700, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[19] = '{"nop_ie", 16'h0000, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[20] = '{"di",     16'h0800, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[21] = '{"sys_bad",16'h0F00, 3'b000, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

    do_reset();

    // Single-cycle instructions from S_EXEC
    for (int k = 0; k < 22; k++) begin
      instr = tbl[k].instr; alu_flags = tbl[k].flags; instr_valid = 1'b1;
      e = base(tbl[k].instr, tbl[k].ie, 3'd0);
      e.alu_op = tbl[k].alu_op; e.incdec = tbl[k].incdec;
      e.reg_we = tbl[k].reg_we; e.wb_sel = tbl[k].wb_sel;
      e.pc_sel = tbl[k].pc_sel; e.pc_en = 1'b1;
      check(tbl[k].name, e);
      tick();
    end
    alu_flags = '0;

    // EI, then a stalled ADD with irq pending: nothing happens
    instr = 16'h0700; e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("ei2", e); tick();
    instr = 16'h8312; instr_valid = 1'b0; irq = 1'b1;
    e = base(instr, 1'b1, 3'd0);
    check("stall_irq", e); tick();
    // Interrupt replaces ADD
    instr_valid = 1'b1;
    e = base(instr, 1'b1, 3'd0); e.stk = 2'b01; e.pc_sel = 2'd3; e.pc_en = 1'b1;
    check("irq_take", e); tick();
    irq = 1'b0; instr = 16'h0600;
    e = base(instr, 1'b0, 3'd0); e.stk = 2'b10; e.pc_sel = 2'd2; e.pc_en = 1'b1;
    check("reti", e); tick();
    instr = 16'h0000; e = base(instr, 1'b1, 3'd0); e.pc_en = 1'b1;
    check("reti_ie", e); tick();
    instr = 16'h0800; e = base(instr, 1'b1, 3'd0); e.pc_en = 1'b1;
    check("di2", e); tick();

    // LW r4,r1,r2 with three not-ready cycles
    instr = 16'h2412; mem_ready = 1'b0;
    e = base(instr, 1'b0, 3'd0); e.le = 1'b1;
    check("lw_addr", e); tick();
    for (int c = 0; c < 3; c++) begin
      e = base(instr, 1'b0, 3'd1); e.req = 1'b1;
      check("lw_wait", e); tick();
    end
    mem_ready = 1'b1;
    e = base(instr, 1'b0, 3'd1); e.req = 1'b1; e.reg_we = 1'b1;
    e.wb_sel = 2'd2; e.pc_en = 1'b1;
    check("lw_done", e); tick();

    // SW r5 with immediate ready
    instr = 16'h3512;
    e = base(instr, 1'b0, 3'd0); e.le = 1'b1;
    check("sw_addr", e); tick();
    e = base(instr, 1'b0, 3'd1); e.rf1 = 4'd5; e.rf2 = 4'd5; e.alu_op = 4'h2;
    e.req = 1'b1; e.we = 1'b1; e.pc_en = 1'b1;
    check("sw_done", e); tick();
    mem_ready = 1'b0;

    // TWC r5,r6
    instr = 16'hF561;
    e = base(instr, 1'b0, 3'd0); e.alu_op = 4'h7; e.reg_we = 1'b1;
    check("twc_1", e); tick();
    e = base(instr, 1'b0, 3'd2); e.incdec = 1'b1; e.rf1 = 4'd5;
    e.reg_we = 1'b1; e.pc_en = 1'b1;
    check("twc_2", e); tick();

    // WAIT released by wake
    instr = 16'h0200; e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("wait", e); tick();
    instr = 16'h0000; instr_valid = 1'b0;
    check("wait_hold", base(instr, 1'b0, 3'd3)); tick();
    wake = 1'b1;
    check("wait_wake", base(instr, 1'b0, 3'd3)); tick();
    wake = 1'b0; instr_valid = 1'b1;
    e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("after_wake", e); tick();

    // SLEEP ignores wake, leaves on irq without vector when ie=0
    instr = 16'h0300; e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("sleep", e); tick();
    instr = 16'h0000; instr_valid = 1'b0; wake = 1'b1;
    check("sleep_wake", base(instr, 1'b0, 3'd4)); tick();
    wake = 1'b0; irq = 1'b1;
    check("sleep_irq", base(instr, 1'b0, 3'd4)); tick();
    irq = 1'b0; instr_valid = 1'b1;
    e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("after_sleep", e); tick();

    // WAIT with ie=1: irq beats wake and vectors directly
    instr = 16'h0700; e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("ei3", e); tick();
    instr = 16'h0200; e = base(instr, 1'b1, 3'd0); e.pc_en = 1'b1;
    check("wait2", e); tick();
    instr = 16'h0000; instr_valid = 1'b0; irq = 1'b1; wake = 1'b1;
    e = base(instr, 1'b1, 3'd3); e.stk = 2'b01; e.pc_sel = 2'd3; e.pc_en = 1'b1;
    check("wait_irq", e); tick();
    irq = 1'b0; wake = 1'b0; instr_valid = 1'b1;
    e = base(instr, 1'b0, 3'd0); e.pc_en = 1'b1;
    check("after_wait_irq", e); tick();
    instr = 16'h0500;
    e = base(instr, 1'b0, 3'd0); e.stk = 2'b10; e.pc_sel = 2'd2; e.pc_en = 1'b1;
    check("ret", e); tick();

    // RET on an empty stack: suppressed, underflow, halt
    e = base(instr, 1'b0, 3'd0); e.pc_sel = 2'd2;
    check("ret_unf", e); tick();
    instr = 16'h0000;
    e = base(instr, 1'b0, 3'd5); e.unf = 1'b1;
    check("halt_unf", e); tick();

    do_reset();

    // Three CALLs against a depth-2 stack
    instr = 16'h0400; instr_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      e = base(instr, 1'b0, 3'd0); e.stk = 2'b01; e.pc_sel = 2'd1; e.pc_en = 1'b1;
      check("call_push", e); tick();
    end
    e = base(instr, 1'b0, 3'd0); e.pc_sel = 2'd1;
    check("call_ovf", e); tick();
    instr = 16'h8312; wake = 1'b1; irq = 1'b1;
    e = base(instr, 1'b0, 3'd5); e.ovf = 1'b1;
    check("halt_ovf", e); tick();
    check("halt_stay", e); tick();

    do_reset();
    instr = 16'h8312; instr_valid = 1'b1;
    e = base(instr, 1'b0, 3'd0); e.reg_we = 1'b1; e.pc_en = 1'b1;
    check("post_reset_add", e); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
